// File: rtl/m_sramarb.sv
// Two-master SRAM arbiter (core vs DMA) with round-robin tie-break.
// Define SRAMARB_TIMEOUT_EN to add the grant timeout and err outputs.
module m_sramarb #(
   parameter int SRAMADRWIDTH = 17,
   parameter int TOCYCLES     = 255
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    core_stb,
   input  logic                    core_we,
   input  logic [3:0]              core_sel,
   input  logic [SRAMADRWIDTH-1:0] core_adr,
   input  logic [31:0]             core_dat,
   output logic                    core_ack,
   output logic                    core_err,
   input  logic                    dma_stb,
   input  logic                    dma_we,
   input  logic [3:0]              dma_sel,
   input  logic [SRAMADRWIDTH-1:0] dma_adr,
   input  logic [31:0]             dma_dat,
   output logic                    dma_ack,
   output logic                    dma_err,
   output logic                    sram_stb,
   output logic                    sram_we,
   output logic [3:0]              sram_sel,
   output logic [SRAMADRWIDTH-1:0] sram_adr,
   output logic [31:0]             sram_dat,
   input  logic                    sram_ack,
   output logic [1:0]              owner
);

   if (TOCYCLES < 2 || TOCYCLES > 255) begin : g_bad_tocycles
      $error("m_sramarb: TOCYCLES out of range 2..255");
   end

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CORE = 2'b01,
      DMA  = 2'b10
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   lastdma;
   logic   busy;
   logic   grant_core;
   logic   grant_dma;
   logic   tmo;
   logic   done;

   assign busy = (state != IDLE);

   // lastdma set means DMA was served last, so the core wins a tie
   assign grant_core = (state == IDLE) && core_stb
                       && (!dma_stb || lastdma);
   assign grant_dma  = (state == IDLE) && dma_stb
                       && (!core_stb || !lastdma);

`ifdef SRAMARB_TIMEOUT_EN
   localparam logic [7:0] TOLAST = 8'(TOCYCLES - 1);

   logic [7:0] tocnt;

   assign tmo = busy && !sram_ack && (tocnt == TOLAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tocnt    <= 8'd0;
         core_err <= 1'b0;
         dma_err  <= 1'b0;
      end else begin
         if (grant_core || grant_dma)
            tocnt <= 8'd0;
         else if (busy)
            tocnt <= tocnt + 8'd1;
         core_err <= tmo && (state == CORE);
         dma_err  <= tmo && (state == DMA);
      end
   end
`else
   assign tmo      = 1'b0;
   assign core_err = 1'b0;
   assign dma_err  = 1'b0;
`endif

   assign done = busy && (sram_ack || tmo);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (grant_core)
               state_nxt = CORE;
            else if (grant_dma)
               state_nxt = DMA;
         end
         CORE, DMA: begin
            if (done)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      owner    = state;
      core_ack = sram_ack && (state == CORE);
      dma_ack  = sram_ack && (state == DMA);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lastdma  <= 1'b1;
         sram_stb <= 1'b0;
         sram_we  <= 1'b0;
         sram_sel <= 4'd0;
         sram_adr <= '0;
         sram_dat <= 32'd0;
      end else begin
         if (done)
            lastdma <= (state == DMA);
         if (grant_core) begin
            sram_stb <= 1'b1;
            sram_we  <= core_we;
            sram_sel <= core_sel;
            sram_adr <= core_adr;
            sram_dat <= core_dat;
         end else if (grant_dma) begin
            sram_stb <= 1'b1;
            sram_we  <= dma_we;
            sram_sel <= dma_sel;
            sram_adr <= dma_adr;
            sram_dat <= dma_dat;
         end else if (done) begin
            sram_stb <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_m_sramarb.sv
// Directed bench for m_sramarb.
// Timeout cases run when SRAMARB_TIMEOUT_EN is defined.
module tb_m_sramarb;

   localparam int AW = 17;

   logic          clk;
   logic          rstn;
   logic          core_stb;
   logic          core_we;
   logic [3:0]    core_sel;
   logic [AW-1:0] core_adr;
   logic [31:0]   core_dat;
   logic          core_ack;
   logic          core_err;
   logic          dma_stb;
   logic          dma_we;
   logic [3:0]    dma_sel;
   logic [AW-1:0] dma_adr;
   logic [31:0]   dma_dat;
   logic          dma_ack;
   logic          dma_err;
   logic          sram_stb;
   logic          sram_we;
   logic [3:0]    sram_sel;
   logic [AW-1:0] sram_adr;
   logic [31:0]   sram_dat;
   logic          sram_ack;
   logic [1:0]    owner;

   int checks = 0;
   int errors = 0;

   m_sramarb #(
      .SRAMADRWIDTH(AW),
      .TOCYCLES(4)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .core_stb(core_stb),
      .core_we(core_we),
      .core_sel(core_sel),
      .core_adr(core_adr),
      .core_dat(core_dat),
      .core_ack(core_ack),
      .core_err(core_err),
      .dma_stb(dma_stb),
      .dma_we(dma_we),
      .dma_sel(dma_sel),
      .dma_adr(dma_adr),
      .dma_dat(dma_dat),
      .dma_ack(dma_ack),
      .dma_err(dma_err),
      .sram_stb(sram_stb),
      .sram_we(sram_we),
      .sram_sel(sram_sel),
      .sram_adr(sram_adr),
      .sram_dat(sram_dat),
      .sram_ack(sram_ack),
      .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] seq [4];
      seq[0] = 2'b01;
      seq[1] = 2'b10;
      seq[2] = 2'b01;
      seq[3] = 2'b10;

      rstn     = 1'b0;
      core_stb = 1'b0;
      core_we  = 1'b0;
      core_sel = 4'd0;
      core_adr = '0;
      core_dat = 32'd0;
      dma_stb  = 1'b0;
      dma_we   = 1'b0;
      dma_sel  = 4'd0;
      dma_adr  = '0;
      dma_dat  = 32'd0;
      sram_ack = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_stb", 32'(sram_stb), 32'h0);
      chk("rst_adr", 32'(sram_adr), 32'h0);
      chk("rst_sel", 32'(sram_sel), 32'h0);
      chk("rst_dat", sram_dat, 32'h0);
      chk("rst_we", 32'(sram_we), 32'h0);
      chk("rst_err", 32'({core_err, dma_err}), 32'h0);
      rstn = 1'b1;

      // core-only write, ack on the 3rd cycle
      core_stb = 1'b1;
      core_we  = 1'b1;
      core_sel = 4'b0011;
      core_adr = 17'h00123;
      core_dat = 32'hDEADBEEF;
      chk("cw_pre_stb", 32'(sram_stb), 32'h0);
      tick();
      chk("cw_stb", 32'(sram_stb), 32'h1);
      chk("cw_owner", 32'(owner), 32'h1);
      chk("cw_adr", 32'(sram_adr), 32'h123);
      chk("cw_sel", 32'(sram_sel), 32'h3);
      chk("cw_we", 32'(sram_we), 32'h1);
      chk("cw_dat", sram_dat, 32'hDEADBEEF);
      core_stb = 1'b0;
      core_adr = 17'h1FFFF;
      core_sel = 4'b1111;
      tick();
      chk("cw_hold_adr", 32'(sram_adr), 32'h123);
      chk("cw_hold_sel", 32'(sram_sel), 32'h3);
      chk("cw_noack", 32'(core_ack), 32'h0);
      tick();
      sram_ack = 1'b1;
      #1;
      chk("cw_core_ack", 32'(core_ack), 32'h1);
      chk("cw_dma_ack", 32'(dma_ack), 32'h0);
      tick();
      chk("cw_owner_idle", 32'(owner), 32'h0);
      chk("cw_stb_clr", 32'(sram_stb), 32'h0);

      // stray ack in IDLE
      chk("stray_core_ack", 32'(core_ack), 32'h0);
      chk("stray_dma_ack", 32'(dma_ack), 32'h0);
      tick();
      chk("stray_owner", 32'(owner), 32'h0);
      sram_ack = 1'b0;

      // tie fairness from a fresh reset
      rst_pulse();
      core_stb = 1'b1;
      core_adr = 17'h0AAAA;
      dma_stb  = 1'b1;
      dma_adr  = 17'h15555;
      dma_we   = 1'b0;
      dma_sel  = 4'b1100;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("tie_owner", 32'(owner), 32'(seq[i]));
         chk("tie_adr", 32'(sram_adr),
             (seq[i] == 2'b01) ? 32'h0AAAA : 32'h15555);
         sram_ack = 1'b1;
         #1;
         chk("tie_core_ack", 32'(core_ack), 32'(seq[i] == 2'b01));
         chk("tie_dma_ack", 32'(dma_ack), 32'(seq[i] == 2'b10));
         tick();
         chk("tie_idle", 32'(owner), 32'h0);
         sram_ack = 1'b0;
      end
      dma_stb = 1'b0;

      // reset mid-grant
      tick();
      chk("rmg_owner", 32'(owner), 32'h1);
      rstn     = 1'b0;
      sram_ack = 1'b1;
      #1;
      chk("rmg_owner_rst", 32'(owner), 32'h0);
      chk("rmg_stb_rst", 32'(sram_stb), 32'h0);
      chk("rmg_no_ack", 32'(core_ack), 32'h0);
      sram_ack = 1'b0;
      #1;
      rstn = 1'b1;
      #1;
      chk("rmg_owner_rel", 32'(owner), 32'h0);
      tick();
      chk("rmg_regrant", 32'(owner), 32'h1);
      chk("rmg_regrant_stb", 32'(sram_stb), 32'h1);
      core_stb = 1'b0;
      sram_ack = 1'b1;
      tick();
      sram_ack = 1'b0;
      tick();

`ifdef SRAMARB_TIMEOUT_EN
      // timeout, no ack ever
      dma_stb = 1'b1;
      tick();
      chk("to_grant", 32'(owner), 32'h2);
      dma_stb = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("to_wait_owner", 32'(owner), 32'h2);
         chk("to_wait_err", 32'(dma_err), 32'h0);
      end
      tick();
      chk("to_dma_err", 32'(dma_err), 32'h1);
      chk("to_core_err", 32'(core_err), 32'h0);
      tick();
      chk("to_err_pulse", 32'(dma_err), 32'h0);
      chk("to_stb", 32'(sram_stb), 32'h0);
      chk("to_owner", 32'(owner), 32'h0);
      chk("to_core_err2", 32'(core_err), 32'h0);

      // ack on the same cycle as the timeout
      dma_stb = 1'b1;
      tick();
      chk("col_grant", 32'(owner), 32'h2);
      dma_stb = 1'b0;
      tick();
      tick();
      tick();
      sram_ack = 1'b1;
      #1;
      chk("col_dma_ack", 32'(dma_ack), 32'h1);
      tick();
      sram_ack = 1'b0;
      chk("col_dma_err", 32'(dma_err), 32'h0);
      chk("col_owner", 32'(owner), 32'h0);
`else
      // no timeout: grant waits indefinitely
      core_stb = 1'b1;
      tick();
      core_stb = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      chk("nto_owner", 32'(owner), 32'h1);
      chk("nto_stb", 32'(sram_stb), 32'h1);
      chk("nto_err", 32'({core_err, dma_err}), 32'h0);
      sram_ack = 1'b1;
      #1;
      chk("nto_ack", 32'(core_ack), 32'h1);
      tick();
      sram_ack = 1'b0;
      chk("nto_idle", 32'(owner), 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
